// File: rtl/drum_pkg.sv
// Shared types and voice tables for the drum voice controller.
// Pad order: 0 kick, 1 snare, 2 hihat, 3 tom.
package drum_pkg;

    typedef enum logic {
        IDLE,
        PLAY
    } voice_state_t;

    // Packed tables: element [i] belongs to pad i.
    localparam logic [3:0][15:0] BASE_TOP = {
        16'd700, 16'd100, 16'd400, 16'd1000
    };
    localparam logic [3:0][15:0] SWEEP = {
        16'd4, 16'd0, 16'd2, 16'd8
    };
    localparam logic [3:0][7:0] DUR_TICKS = {
        8'd160, 8'd40, 8'd120, 8'd200
    };

    // 17-bit add that clamps at 16'hFFFF instead of wrapping.
    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/drum_voice_ctrl_tick_divider.sv
// Decay tick generator: counts 0..TICK_DIV-1 while en, pulses tick on the
// last count. Ports: clk, reset (async high), en, clr (restart), tick out.
module tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/drum_voice_ctrl.sv
// Per-hit tone controller feeding the PWM Top (period) input.
// Ports: clk, reset (async high), hit/pad in; Top, gate, busy out.
module drum_voice_ctrl
    import drum_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DUR_W = 8,
    parameter logic [3:0][15:0] BASE_TABLE = BASE_TOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hit,
    input  logic [1:0]  pad,
    output logic [15:0] Top,
    output logic        gate,
    output logic        busy
);

    voice_state_t state_q, state_d;
    logic [15:0] top_q, top_d;
    logic gate_q, gate_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] dur_ld;
    logic [1:0] pad_q, pad_d;
    logic tick;
    logic tick_en;

    // A zero-length table entry still sounds for one tick.
    assign dur_ld = (DUR_TICKS[pad] == 8'd0) ? DUR_W'(1)
                                              : DUR_W'(DUR_TICKS[pad]);

    assign tick_en = (state_q == PLAY);

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (tick_en),
        .clr  (hit),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        gate_d  = gate_q;
        dur_d   = dur_q;
        pad_d   = pad_q;
        // A hit always wins, including over the final tick of a voice.
        if (hit) begin
            state_d = PLAY;
            top_d   = BASE_TABLE[pad];
            gate_d  = 1'b1;
            dur_d   = dur_ld;
            pad_d   = pad;
        end else if (state_q == PLAY && tick) begin
            if (dur_q <= DUR_W'(1)) begin
                state_d = IDLE;
                top_d   = '0;
                gate_d  = 1'b0;
                dur_d   = '0;
            end else begin
                top_d = sat_add(top_q, SWEEP[pad_q]);
                dur_d = dur_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            top_q   <= '0;
            gate_q  <= 1'b0;
            dur_q   <= '0;
            pad_q   <= '0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            gate_q  <= gate_d;
            dur_q   <= dur_d;
            pad_q   <= pad_d;
        end
    end

    assign Top  = top_q;
    assign gate = gate_q;
    assign busy = gate_q;

endmodule
